ublock_round_ctrl: RTL and testbench
====================================

Name: ublock_round_ctrl

Overview:
Round-sequencing controller for the masked (threshold-implementation, decomposed S-box) uBlock encryption core. It accepts a block from the host and steps the datapath through load, the multi-cycle shared S-box stages, the linear/key-update step and final whitening. It also drives the enable and advance inputs of the round-constant LFSR generator, then holds the result until the host acknowledges it.

Parameters:
NUM_ROUNDS, 16, number of cipher rounds (16 for uBlock-128/128; 24 for the 128/256 and 256/256 variants)
SBOX_STAGES, 3, register stages of the decomposed TI S-box per round (minimum 1)
RW, $clog2(NUM_ROUNDS+1), width of the round index
SW, $clog2(SBOX_STAGES) (minimum 1), width of the S-box stage index

Ports:
clk  in  1  system clock, all flops on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  host request to start; accepted only when in_ready=1
abort  in  1  synchronous abort; returns the block to IDLE
in_ready  out  1  high only in IDLE
data_load  out  1  datapath loads masked plaintext and key shares
sbox_en  out  1  S-box stage register enable
sbox_stage  out  SW  current S-box stage, 0..SBOX_STAGES-1
linear_en  out  1  linear layer, key schedule and round-key addition enable
final_en  out  1  final round-key whitening enable
round_const_ena  out  1  to the round-constant generator: 0 holds the LFSR at its seed, 1 runs
round_cnt  out  1  to the round-constant generator: one-cycle advance pulse
round_idx  out  RW  completed-round count, 0..NUM_ROUNDS
last_round  out  1  high while round_idx==NUM_ROUNDS-1 in SBOX/LINEAR
out_valid  out  1  result shares valid
out_ack  in  1  host consumes the result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: IDLE state; in_ready=1; every other output 0, including round_idx, sbox_stage and round_const_ena.
- State machine states: IDLE, LOAD, SBOX, LINEAR, FINAL, DONE.
- IDLE:
  - round_const_ena=0, so the generator holds its seed.
  - start=1 at a clock edge moves to LOAD; round_idx is cleared to 0.
- LOAD (1 cycle):
  - data_load=1, round_const_ena=0.
  - Moves to SBOX with sbox_stage=0.
- SBOX (SBOX_STAGES cycles):
  - sbox_en=1, round_const_ena=1.
  - sbox_stage increments each cycle.
  - After stage SBOX_STAGES-1, moves to LINEAR.
- LINEAR (1 cycle):
  - linear_en=1, round_cnt=1, round_const_ena=1.
  - round_idx increments at the end of this cycle.
  - If the incremented round_idx equals NUM_ROUNDS, moves to FINAL; otherwise to SBOX with stage 0.
- round_cnt pulses:
  - Exactly one per round, NUM_ROUNDS in total.
  - Never asserted outside LINEAR.
- FINAL (1 cycle):
  - final_en=1, round_const_ena=1, round_cnt=0.
  - Moves to DONE.
- DONE:
  - out_valid=1 and stays 1 until out_ack=1 is sampled.
  - round_idx holds NUM_ROUNDS; round_const_ena=1 and the LFSR is not advanced.
  - On out_ack, moves to IDLE next cycle with out_valid=0.
- Latency:
  - Accepting edge to first out_valid cycle = 2 + NUM_ROUNDS*(SBOX_STAGES+1) cycles.
  - This is 66 cycles at the defaults.
- Enable exclusivity: data_load, sbox_en, linear_en and final_en are mutually exclusive and registered (state-decoded, glitch-free).
- start outside IDLE is ignored and not queued. start together with out_ack in DONE: out_ack is honoured, start is ignored.
- abort:
  - Any state except IDLE moves to IDLE next cycle, with all enables 0, out_valid=0 and round_idx=0.
  - round_const_ena=0 from that cycle, re-seeding the LFSR.
  - abort takes priority over every other transition, including out_ack.
  - abort in IDLE has no effect; abort together with start in IDLE: abort wins and start is dropped.
- Asynchronous reset mid-operation: immediate return to the reset values; no partial result is presented.
- No combinational path from start, abort or out_ack to any output.

Test Plan:
- Reset, then idle 5 cycles -> in_ready=1, busy=0, round_const_ena=0, all other outputs 0.
- Single encryption with defaults: start for 1 cycle -> data_load for 1 cycle; 16 rounds of 3 sbox_en cycles (stage 0,1,2) plus 1 linear_en cycle; 16 round_cnt pulses; final_en; out_valid exactly 66 cycles after the accepting edge; round_idx=16.
- Hold out_ack=0 for 10 cycles in DONE -> out_valid stays 1 and no extra round_cnt; out_ack=1 -> IDLE next cycle; a new start then gives an identical trace.
- Assert abort in round 7, stage 1 -> next cycle IDLE, round_idx=0, round_const_ena=0; a following start yields the full 66-cycle sequence.
- Reassert start every cycle during busy, including together with out_ack in DONE -> no extra operation and no trace change.
- NUM_ROUNDS=24, SBOX_STAGES=1 -> 24 round_cnt pulses, alternating sbox_en and linear_en, out_valid after 50 cycles; rstn low mid-round 10 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ublock_round_ctrl.sv
// Round sequencer for the masked uBlock core: walks the datapath through
// load, the staged TI S-box, the linear/key step and whitening, and drives the round-constant LFSR.
module ublock_round_ctrl #(
  parameter int NUM_ROUNDS  = 16,
  parameter int SBOX_STAGES = 3,
  parameter int RW          = $clog2(NUM_ROUNDS + 1),
  parameter int SW          = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic          in_ready,
  output logic          data_load,
  output logic          sbox_en,
  output logic [SW-1:0] sbox_stage,
  output logic          linear_en,
  output logic          final_en,
  output logic          round_const_ena,
  output logic          round_cnt,
  output logic [RW-1:0] round_idx,
  output logic          last_round,
  output logic          out_valid,
  input  logic          out_ack,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshakes: start is taken at a rising edge only while in_ready=1;
  // out_valid then stays high until out_ack=1 is sampled at a rising edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SBOX   = 3'd2,
    S_LINEAR = 3'd3,
    S_FINAL  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [SW-1:0] LAST_STAGE = SW'(SBOX_STAGES - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

  state_t        r_state;
  logic [SW-1:0] r_stage;
  logic [RW-1:0] r_round;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_data_load;
  logic          r_sbox_en;
  logic          r_linear_en;
  logic          r_final_en;
  logic          r_rc_ena;
  logic          r_round_cnt;
  logic          r_last_round;
  logic          r_out_valid;

  state_t        w_next_state;
  logic [SW-1:0] w_next_stage;
  logic [RW-1:0] w_next_round;

  always_comb begin
    w_next_state = r_state;
    w_next_stage = '0;
    w_next_round = r_round;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_next_state = S_LOAD;
          w_next_round = '0;
        end
      end
      S_LOAD: begin
        w_next_state = S_SBOX;
      end
      S_SBOX: begin
        if (r_stage == LAST_STAGE) begin
          w_next_state = S_LINEAR;
        end else begin
          w_next_stage = r_stage + SW'(1);
        end
      end
      S_LINEAR: begin
        w_next_round = r_round + RW'(1);
        w_next_state = (r_round == LAST_ROUND) ? S_FINAL : S_SBOX;
      end
      S_FINAL: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (out_ack) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_round = '0;
      end
    endcase
    // Abort outranks everything, including out_ack in DONE.
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_next_stage = '0;
      w_next_round = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so every
  // enable is a clean flop output with no path from the host inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_stage      <= '0;
      r_round      <= '0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_data_load  <= 1'b0;
      r_sbox_en    <= 1'b0;
      r_linear_en  <= 1'b0;
      r_final_en   <= 1'b0;
      r_rc_ena     <= 1'b0;
      r_round_cnt  <= 1'b0;
      r_last_round <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_stage      <= w_next_stage;
      r_round      <= w_next_round;
      r_in_ready   <= (w_next_state == S_IDLE);
      r_busy       <= (w_next_state != S_IDLE);
      r_data_load  <= (w_next_state == S_LOAD);
      r_sbox_en    <= (w_next_state == S_SBOX);
      r_linear_en  <= (w_next_state == S_LINEAR);
      r_final_en   <= (w_next_state == S_FINAL);
      r_rc_ena     <= (w_next_state == S_SBOX) || (w_next_state == S_LINEAR) ||
                      (w_next_state == S_FINAL) || (w_next_state == S_DONE);
      r_round_cnt  <= (w_next_state == S_LINEAR);
      r_last_round <= ((w_next_state == S_SBOX) || (w_next_state == S_LINEAR)) &&
                      (w_next_round == LAST_ROUND);
      r_out_valid  <= (w_next_state == S_DONE);
    end
  end

  assign in_ready        = r_in_ready;
  assign busy            = r_busy;
  assign data_load       = r_data_load;
  assign sbox_en         = r_sbox_en;
  assign sbox_stage      = r_stage;
  assign linear_en       = r_linear_en;
  assign final_en        = r_final_en;
  assign round_const_ena = r_rc_ena;
  assign round_cnt       = r_round_cnt;
  assign round_idx       = r_round;
  assign last_round      = r_last_round;
  assign out_valid       = r_out_valid;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_ublock_round_ctrl.sv
// Bench for ublock_round_ctrl: a default instance and a 24-round/1-stage instance,
// both compared every cycle against a cycle-count reference model.
module tb_ublock_round_ctrl;

  localparam int VW = 17;
  localparam int N0 = 16, S0 = 3;
  localparam int N1 = 24, S1 = 1;

  logic       clk;
  logic       rstn;
  logic [1:0] st, ab, ak;

  logic       ir0, bz0, dl0, sb0, le0, fe0, rce0, rc0, lr0, ov0;
  logic [1:0] stg0;
  logic [4:0] idx0;
  logic [2:0] dbg0;
  logic       ir1, bz1, dl1, sb1, le1, fe1, rce1, rc1, lr1, ov1;
  logic       stg1;
  logic [4:0] idx1;
  logic [2:0] dbg1;

  ublock_round_ctrl #(.NUM_ROUNDS(N0), .SBOX_STAGES(S0)) dut0 (
    .clk(clk), .rstn(rstn), .start(st[0]), .abort(ab[0]), .in_ready(ir0),
    .data_load(dl0), .sbox_en(sb0), .sbox_stage(stg0), .linear_en(le0),
    .final_en(fe0), .round_const_ena(rce0), .round_cnt(rc0), .round_idx(idx0),
    .last_round(lr0), .out_valid(ov0), .out_ack(ak[0]), .busy(bz0), .dbg_state(dbg0)
  );

  ublock_round_ctrl #(.NUM_ROUNDS(N1), .SBOX_STAGES(S1)) dut1 (
    .clk(clk), .rstn(rstn), .start(st[1]), .abort(ab[1]), .in_ready(ir1),
    .data_load(dl1), .sbox_en(sb1), .sbox_stage(stg1), .linear_en(le1),
    .final_en(fe1), .round_const_ena(rce1), .round_cnt(rc1), .round_idx(idx1),
    .last_round(lr1), .out_valid(ov1), .out_ack(ak[1]), .busy(bz1), .dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: per unit, active flag, cycles since accept, idle round index
  int  mn[2] = '{N0, N1};
  int  ms[2] = '{S0, S1};
  bit  m_act[2];
  int  m_j[2];
  int  m_idx[2];

  logic [VW-1:0] exp0_q[$];
  logic [VW-1:0] exp1_q[$];

  function automatic logic [VW-1:0] pack(bit ir, bit bz, bit dl, bit sb, int stage,
                                          bit le, bit fe, bit rce, bit rc, int idx,
                                          bit lr, bit ov);
    logic [1:0] s2;
    logic [4:0] i5;
    s2 = 2'(stage);
    i5 = 5'(idx);
    return {ir, bz, dl, sb, s2, le, fe, rce, rc, i5, lr, ov};
  endfunction

  function automatic logic [VW-1:0] idle_vec(int idx);
    return pack(1, 0, 0, 0, 0, 0, 0, 0, 0, idx, 0, 0);
  endfunction

  // j = cycles elapsed since the accepting edge (0 = load cycle)
  function automatic logic [VW-1:0] trace_vec(int j, int n, int s);
    int t, r, p;
    if (j == 0) return pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (j <= n * (s + 1)) begin
      t = j - 1;
      r = t / (s + 1);
      p = t % (s + 1);
      if (p < s) return pack(0, 1, 0, 1, p, 0, 0, 1, 0, r, r == n - 1, 0);
      return pack(0, 1, 0, 0, 0, 1, 0, 1, 1, r, r == n - 1, 0);
    end
    if (j == n * (s + 1) + 1) return pack(0, 1, 0, 0, 0, 0, 1, 1, 0, n, 0, 0);
    return pack(0, 1, 0, 0, 0, 0, 0, 1, 0, n, 0, 1);
  endfunction

  function automatic logic [VW-1:0] model_vec(int u);
    if (m_act[u]) return trace_vec(m_j[u], mn[u], ms[u]);
    return idle_vec(m_idx[u]);
  endfunction

  task automatic model_step(input int u);
    int done_j;
    done_j = mn[u] * (ms[u] + 1) + 2;
    if (!m_act[u]) begin
      if (st[u] && !ab[u]) begin
        m_act[u] = 1;
        m_j[u]   = 0;
      end
    end else if (ab[u]) begin
      m_act[u] = 0;
      m_idx[u] = 0;
    end else if (m_j[u] >= done_j && ak[u]) begin
      m_act[u] = 0;
      m_idx[u] = mn[u];
    end else if (m_j[u] < done_j) begin
      m_j[u] = m_j[u] + 1;
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 0;
      m_j[u]   = 0;
      m_idx[u] = 0;
    end
    exp0_q.delete();
    exp1_q.delete();
  endtask

  function automatic logic [VW-1:0] obs0();
    return {ir0, bz0, dl0, sb0, stg0, le0, fe0, rce0, rc0, idx0, lr0, ov0};
  endfunction

  function automatic logic [VW-1:0] obs1();
    return {ir1, bz1, dl1, sb1, 1'b0, stg1, le1, fe1, rce1, rc1, idx1, lr1, ov1};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] o, input logic [VW-1:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // scoreboard tick: model advances at the edge, outputs compared at the falling edge
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    exp0_q.push_back(model_vec(0));
    exp1_q.push_back(model_vec(1));
    @(negedge clk);
    cyc++;
    check("dut0_trace", obs0(), exp0_q.pop_front());
    check("dut1_trace", obs1(), exp1_q.pop_front());
  endtask

  // driver: one full operation, measuring latency and round_cnt pulses
  task automatic run_op(input int u, input bit rand_start);
    int lat, pulses;
    bit ov;
    st[u] = 1'b1;
    tick();
    st[u] = 1'b0;
    lat = 0;
    pulses = 0;
    ov = (u == 0) ? ov0 : ov1;
    while (!ov && lat < 200) begin
      if (rand_start) st[u] = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if ((u == 0) ? rc0 : rc1) pulses++;
      ov = (u == 0) ? ov0 : ov1;
    end
    st[u] = 1'b0;
    check_int(u == 0 ? "dut0_latency" : "dut1_latency", lat, 2 + mn[u] * (ms[u] + 1));
    check_int(u == 0 ? "dut0_round_pulses" : "dut1_round_pulses", pulses, mn[u]);
  endtask

  task automatic hold_and_ack(input int u, input int hold, input bit start_too);
    int pulses;
    pulses = 0;
    ak[u] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if ((u == 0) ? rc0 : rc1) pulses++;
    end
    check_int("done_hold_pulses", pulses, 0);
    ak[u] = 1'b1;
    st[u] = start_too;
    tick();
    ak[u] = 1'b0;
    st[u] = 1'b0;
  endtask

  initial begin
    int guard;
    st = '0;
    ab = '0;
    ak = '0;
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check("reset_dut0", obs0(), idle_vec(0));
    check("reset_dut1", obs1(), idle_vec(0));
    for (int i = 0; i < 5; i++) tick();

    // single encryption, long DONE hold, then an identical second run
    run_op(0, 1'b0);
    hold_and_ack(0, 10, 1'b0);
    tick();
    run_op(0, 1'b0);
    hold_and_ack(0, 3, 1'b0);

    // abort in round 7, stage 1
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    guard = 0;
    while (m_j[0] != 1 + 7 * (S0 + 1) + 1 && guard < 100) begin
      tick();
      guard++;
    end
    check_int("abort_point_reached", int'(stg0), 1);
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    check("after_abort", obs0(), idle_vec(0));
    run_op(0, 1'b0);
    hold_and_ack(0, 2, 1'b0);

    // abort with start in IDLE: start dropped
    ab[0] = 1'b1;
    st[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    st[0] = 1'b0;
    tick();

    // start hammered while busy, and together with out_ack in DONE
    run_op(0, 1'b1);
    hold_and_ack(0, 4, 1'b1);
    tick();

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      st = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      ab = {1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 60) == 0)};
      ak = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      tick();
    end
    st = '0;
    ab = '1;
    ak = '0;
    tick();
    ab = '0;
    tick();

    // 24-round / single-stage instance
    run_op(1, 1'b1);
    hold_and_ack(1, 5, 1'b1);
    tick();

    // asynchronous reset in round 10 of the second instance
    st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    guard = 0;
    while (m_j[1] != 1 + 10 * (S1 + 1) && guard < 100) begin
      tick();
      guard++;
    end
    check_int("reset_point_round", int'(idx1), 10);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_dut0", obs0(), idle_vec(0));
    check("async_reset_dut1", obs1(), idle_vec(0));
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    run_op(1, 1'b0);
    hold_and_ack(1, 1, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
